// File: rtl/biquad_pkg.sv
// biquad_pkg: shared definitions for the biquad cascade.
//   - Coefficient slot indices within a stage (A0..B2, five per stage).
//   - FSM state encoding for the frame sequencer.
//   - Operation codes for the shared multiply-accumulate unit.
//   - accw(): accumulator / state width for a given sample width.
//   - saturate(): clamp a wide signed value into a narrower signed range.
package biquad_pkg;

  localparam int NCOEF = 5;
  localparam int A0    = 0;
  localparam int A1    = 1;
  localparam int A2    = 2;
  localparam int B1    = 3;
  localparam int B2    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  typedef enum logic [1:0] {
    MAC_HOLD  = 2'd0,
    MAC_LOAD  = 2'd1,
    MAC_ADD_Z = 2'd2,
    MAC_SUB_P = 2'd3
  } mac_op_e;

  // Product scale plus two guard bits: three products of |coef| < 2 never wrap.
  function automatic int accw(input int bits);
    return 2 * bits + 2;
  endfunction

  // Clamp v to the signed range of a 'bits'-wide word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int                 bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/biquad_mac.sv
// biquad_mac: shared registered multiplier and wide accumulator.
// Ports:
//   bclk   in   clock
//   mul_a  in   signed multiplicand (sample or stage output)
//   mul_b  in   signed coefficient
//   op     in   accumulator operation: hold / load p / p+z / acc-p
//   z      in   state word added by the add_z operation
//   sum    out  p + z (combinational, used for the stage output and add_z)
//   diff   out  acc - p (combinational, used for state write-back and sub_p)
// The product register has one cycle of latency; sum and diff are formed
// from the registered product so the caller sees the product issued on the
// previous step.
module biquad_mac
  import biquad_pkg::*;
#(
  parameter int BITSIZE = 16,
  parameter int ACCW    = 34
) (
  input  logic                      bclk,
  input  logic signed [BITSIZE-1:0] mul_a,
  input  logic signed [BITSIZE-1:0] mul_b,
  input  mac_op_e                   op,
  input  logic signed [ACCW-1:0]    z,
  output logic signed [ACCW-1:0]    sum,
  output logic signed [ACCW-1:0]    diff
);

  logic signed [2*BITSIZE-1:0] prod_p1;
  logic signed [ACCW-1:0]      prod_ext;
  logic signed [ACCW-1:0]      acc_p2;

  // Stage p1: full-precision product
  always_ff @(posedge bclk) begin
    prod_p1 <= (2*BITSIZE)'(mul_a) * (2*BITSIZE)'(mul_b);
  end

  assign prod_ext = ACCW'(prod_p1);
  assign sum      = prod_ext + z;
  assign diff     = acc_p2 - prod_ext;

  // Stage p2: accumulator
  always_ff @(posedge bclk) begin
    case (op)
      MAC_LOAD:  acc_p2 <= prod_ext;
      MAC_ADD_Z: acc_p2 <= sum;
      MAC_SUB_P: acc_p2 <= diff;
      default:   acc_p2 <= acc_p2;
    endcase
  end

endmodule

// File: rtl/biquad_cascade.sv
// biquad_cascade: time-multiplexed cascade of STAGES DF2T biquads applied to
// CHANNELS independent channels, one frame per lrclk rising edge.
// Ports:
//   bclk         in   clock, all logic on posedge
//   rst_n        in   asynchronous active-low reset
//   lrclk        in   frame clock; rising edge starts a frame
//   in           in   CHANNELS packed signed samples, captured at frame start
//   out          out  CHANNELS packed filtered samples, held between frames
//   out_valid    out  one-cycle pulse when out updates
//   busy         out  high while a frame is being processed
//   overrun      out  one-cycle pulse when a frame start is dropped
//   coef_we      in   write coef_data into the shadow bank at coef_addr
//   coef_addr    in   stage*5 + k (k: a0,a1,a2,b1,b2); out-of-range ignored
//   coef_data    in   signed Q2.FRAC coefficient
//   coef_commit  in   copy shadow to active at the next frame start
//   clear        in   zero all filter state (deferred to frame end if busy)
// Each (channel, stage) pair takes six steps through the shared MAC:
//   k0 x*a0 | k1 y=sat((p+z1)>>>FRAC), x*a1 | k2 acc=p+z2, y*b1
//   k3 z1=acc-p, x*a2 | k4 acc=p, y*b2 | k5 z2=acc-p, y feeds next stage
module biquad_cascade
  import biquad_pkg::*;
#(
  parameter int BITSIZE  = 16,
  parameter int FRAC     = BITSIZE - 2,
  parameter int STAGES   = 2,
  parameter int CHANNELS = 2
) (
  input  logic                         bclk,
  input  logic                         rst_n,
  input  logic                         lrclk,
  input  logic [CHANNELS*BITSIZE-1:0]  in,
  output logic [CHANNELS*BITSIZE-1:0]  out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun,
  input  logic                         coef_we,
  input  logic [7:0]                   coef_addr,
  input  logic signed [BITSIZE-1:0]    coef_data,
  input  logic                         coef_commit,
  input  logic                         clear
);

  localparam int ACCW = accw(BITSIZE);
  localparam int NCF  = STAGES * NCOEF;
  localparam int NZ   = CHANNELS * STAGES * 2;
  localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int STW  = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int CIW  = $clog2(NCF);
  localparam int ZIW  = $clog2(NZ);

  fsm_e             state;
  logic             lrclk_d;
  logic             start;
  logic [CHW-1:0]   ch_cnt;
  logic [STW-1:0]   stg_cnt;
  logic [2:0]       k_cnt;
  logic             clr_pend;
  logic             commit_pend;
  logic             do_commit;
  logic             zero_z;
  logic             run;

  logic signed [BITSIZE-1:0] smp [CHANNELS];
  logic signed [BITSIZE-1:0] y_p1;
  logic signed [BITSIZE-1:0] shadow [NCF];
  logic signed [BITSIZE-1:0] active [NCF];
  logic signed [ACCW-1:0]    zmem [NZ];

  logic [CIW-1:0]            cidx;
  logic [ZIW-1:0]            zi1;
  logic [ZIW-1:0]            zi2;
  int                        ksel;
  logic signed [BITSIZE-1:0] mul_a;
  logic signed [BITSIZE-1:0] mul_b;
  mac_op_e                   mac_op;
  logic signed [ACCW-1:0]    zsel;
  logic signed [ACCW-1:0]    sum;
  logic signed [ACCW-1:0]    diff;
  logic signed [ACCW-1:0]    sh;
  logic signed [BITSIZE-1:0] y_sat;

  assign start     = lrclk & ~lrclk_d;
  assign run       = (state == RUN);
  assign do_commit = (state == IDLE) && start && (commit_pend || coef_commit);
  assign zero_z    = ((state == IDLE) && clear) ||
                     ((state == DONE) && (clr_pend || clear));

  // Step decode: coefficient slot, state addresses and MAC operation.
  always_comb begin
    ksel   = A0;
    mul_a  = smp[ch_cnt];
    mac_op = MAC_HOLD;
    case (k_cnt)
      3'd1: begin ksel = A1; mac_op = MAC_ADD_Z; end
      3'd2: begin ksel = B1; mac_op = MAC_ADD_Z; mul_a = y_p1; end
      3'd3: begin ksel = A2; mac_op = MAC_SUB_P; end
      3'd4: begin ksel = B2; mac_op = MAC_LOAD;  mul_a = y_p1; end
      default: begin ksel = A0; mac_op = MAC_HOLD; end
    endcase
    if (!run) mac_op = MAC_HOLD;
    cidx  = CIW'(int'(stg_cnt) * NCOEF + ksel);
    zi1   = ZIW'((int'(ch_cnt) * STAGES + int'(stg_cnt)) * 2);
    zi2   = zi1 + ZIW'(1);
    mul_b = active[cidx];
    zsel  = (k_cnt == 3'd1) ? zmem[zi1] : zmem[zi2];
  end

  biquad_mac #(
    .BITSIZE (BITSIZE),
    .ACCW    (ACCW)
  ) u_mac (
    .bclk  (bclk),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .op    (mac_op),
    .z     (zsel),
    .sum   (sum),
    .diff  (diff)
  );

  // Floor shift back to sample scale, then clamp.
  always_comb begin
    sh    = sum >>> FRAC;
    y_sat = BITSIZE'(saturate(64'(sh), BITSIZE));
  end

  // Frame sequencer and registered outputs.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lrclk_d   <= 1'b0;
      ch_cnt    <= '0;
      stg_cnt   <= '0;
      k_cnt     <= '0;
      clr_pend  <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      lrclk_d   <= lrclk;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ch_cnt  <= '0;
            stg_cnt <= '0;
            k_cnt   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (start) overrun <= 1'b1;
          if (clear) clr_pend <= 1'b1;
          if (k_cnt == 3'd5) begin
            k_cnt <= '0;
            if (stg_cnt == STW'(STAGES - 1)) begin
              stg_cnt <= '0;
              if (ch_cnt == CHW'(CHANNELS - 1)) state <= DONE;
              else ch_cnt <= ch_cnt + CHW'(1);
            end else begin
              stg_cnt <= stg_cnt + STW'(1);
            end
          end else begin
            k_cnt <= k_cnt + 3'd1;
          end
        end
        DONE: begin
          if (start) overrun <= 1'b1;
          for (int c = 0; c < CHANNELS; c++) out[c*BITSIZE +: BITSIZE] <= smp[c];
          out_valid <= 1'b1;
          busy      <= 1'b0;
          clr_pend  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: per-channel running sample and current stage output
  always_ff @(posedge bclk) begin
    if ((state == IDLE) && start) begin
      for (int c = 0; c < CHANNELS; c++) smp[c] <= in[c*BITSIZE +: BITSIZE];
    end else if (run && (k_cnt == 3'd5)) begin
      smp[ch_cnt] <= y_p1;
    end
    if (run && (k_cnt == 3'd1)) y_p1 <= y_sat;
  end

  // Coefficient banks; active only changes at an accepted frame start.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCF; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      commit_pend <= 1'b0;
    end else begin
      if (coef_we && (int'(coef_addr) < NCF)) shadow[coef_addr[CIW-1:0]] <= coef_data;
      if (do_commit) begin
        for (int i = 0; i < NCF; i++) active[i] <= shadow[i];
        commit_pend <= 1'b0;
      end else if (coef_commit) begin
        commit_pend <= 1'b1;
      end
    end
  end

  // Filter state at full product scale.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NZ; i++) zmem[i] <= '0;
    end else if (zero_z) begin
      for (int i = 0; i < NZ; i++) zmem[i] <= '0;
    end else if (run && (k_cnt == 3'd3)) begin
      zmem[zi1] <= diff;
    end else if (run && (k_cnt == 3'd5)) begin
      zmem[zi2] <= diff;
    end
  end

endmodule

// File: tb/tb_biquad_cascade.sv
// tb_biquad_cascade: directed and randomized frames against a behavioural
// model of the cascade (per-sample difference equations on longint values).
module tb_biquad_cascade;

  localparam int BW  = 16;
  localparam int FR  = BW - 2;
  localparam int ST  = 2;
  localparam int CH  = 2;
  localparam int LAT = 6 * CH * ST + 2;

  logic                 bclk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 lrclk = 1'b0;
  logic [CH*BW-1:0]     tin = '0;
  logic [CH*BW-1:0]     tout;
  logic                 out_valid;
  logic                 busy;
  logic                 overrun;
  logic                 coef_we = 1'b0;
  logic [7:0]           coef_addr = '0;
  logic signed [BW-1:0] coef_data = '0;
  logic                 coef_commit = 1'b0;
  logic                 clear = 1'b0;

  always #5 bclk = ~bclk;

  biquad_cascade #(
    .BITSIZE  (BW),
    .FRAC     (FR),
    .STAGES   (ST),
    .CHANNELS (CH)
  ) dut (
    .bclk        (bclk),
    .rst_n       (rst_n),
    .lrclk       (lrclk),
    .in          (tin),
    .out         (tout),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_commit (coef_commit),
    .clear       (clear)
  );

  int     n_chk  = 0;
  int     n_fail = 0;
  longint m_sh  [ST*5];
  longint m_act [ST*5];
  longint m_z   [CH][ST][2];
  longint m_out [CH];
  bit     m_pend = 1'b0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sout(input int c);
    logic signed [BW-1:0] v;
    v = tout[c*BW +: BW];
    return longint'(v);
  endfunction

  function automatic longint msat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint rnd16();
    return longint'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ST*5; i++) begin m_sh[i] = 0; m_act[i] = 0; end
    for (int c = 0; c < CH; c++) begin
      m_out[c] = 0;
      for (int s = 0; s < ST; s++) begin m_z[c][s][0] = 0; m_z[c][s][1] = 0; end
    end
    m_pend = 1'b0;
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++)
      for (int s = 0; s < ST; s++) begin m_z[c][s][0] = 0; m_z[c][s][1] = 0; end
  endtask

  // y = a0 x + z1 ; z1' = a1 x - b1 y + z2 ; z2' = a2 x - b2 y (product scale)
  task automatic model_frame(input longint x0, input longint x1);
    longint x, y, a0, a1, a2, b1, b2, nz1, nz2;
    for (int c = 0; c < CH; c++) begin
      x = (c == 0) ? x0 : x1;
      for (int s = 0; s < ST; s++) begin
        a0 = m_act[s*5+0]; a1 = m_act[s*5+1]; a2 = m_act[s*5+2];
        b1 = m_act[s*5+3]; b2 = m_act[s*5+4];
        y   = msat((x * a0 + m_z[c][s][0]) >>> FR);
        nz1 = x * a1 + m_z[c][s][1] - y * b1;
        nz2 = x * a2 - y * b2;
        m_z[c][s][0] = nz1;
        m_z[c][s][1] = nz2;
        x = y;
      end
      m_out[c] = x;
    end
  endtask

  task automatic wcoef(input int a, input longint d);
    @(negedge bclk);
    coef_we   = 1'b1;
    coef_addr = 8'(a);
    coef_data = BW'(d);
    if (a < ST*5) m_sh[a] = d;
    @(negedge bclk);
    coef_we = 1'b0;
  endtask

  task automatic commit();
    @(negedge bclk);
    coef_commit = 1'b1;
    m_pend = 1'b1;
    @(negedge bclk);
    coef_commit = 1'b0;
  endtask

  task automatic clear_idle();
    @(negedge bclk);
    clear = 1'b1;
    @(negedge bclk);
    clear = 1'b0;
    model_clear();
  endtask

  // One frame: lrclk rises for edge S; cycle S+n is observed at negedge n.
  task automatic run_frame(input longint x0, input longint x1, input int ovr_at,
                           input int clr_at, input int rst_at, input bit cmt_s,
                           input string tag);
    int     nv, vn, no, on;
    longint cap [CH];
    logic   busy1;
    nv = 0; vn = -1; no = 0; on = -1; busy1 = 1'b0;
    cap[0] = 0; cap[1] = 0;
    @(negedge bclk);
    tin         = {BW'(x1), BW'(x0)};
    lrclk       = 1'b1;
    coef_commit = cmt_s;
    if (cmt_s) m_pend = 1'b1;
    if (m_pend) begin m_act = m_sh; m_pend = 1'b0; end
    if (rst_at == 0) model_frame(x0, x1);
    for (int n = 1; n <= 40; n++) begin
      @(negedge bclk);
      coef_commit = 1'b0;
      clear       = 1'b0;
      if (out_valid) begin nv++; vn = n; cap[0] = sout(0); cap[1] = sout(1); end
      if (overrun) begin no++; on = n; end
      if (n == 1) busy1 = busy;
      lrclk = (n <= 2) || (ovr_at > 0 && n >= ovr_at && n <= ovr_at + 2);
      if (n == clr_at) clear = 1'b1;
      if (rst_at > 0 && n == rst_at) rst_n = 1'b0;
      if (rst_at > 0 && n == rst_at + 3) rst_n = 1'b1;
    end
    if (rst_at > 0) begin
      check({tag, "_nvalid"}, nv, 0);
      check({tag, "_out"}, longint'(tout), 0);
      check({tag, "_busy"}, busy, 0);
      model_reset();
    end else begin
      check({tag, "_busy1"}, busy1, 1);
      check({tag, "_nvalid"}, nv, 1);
      check({tag, "_lat"}, vn, LAT);
      check({tag, "_ch0"}, cap[0], m_out[0]);
      check({tag, "_ch1"}, cap[1], m_out[1]);
      check({tag, "_idle"}, busy, 0);
    end
    if (ovr_at > 0) begin
      check({tag, "_novr"}, no, 1);
      check({tag, "_ovr_at"}, on, ovr_at + 1);
    end else begin
      check({tag, "_no_ovr"}, no, 0);
    end
    if (clr_at > 0) model_clear();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge bclk);
    check("rst_out", longint'(tout), 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    // Passthrough: both stages unity
    wcoef(0, 16384); wcoef(5, 16384); commit();
    run_frame(1000, -1000, 0, 0, 0, 0, "pass");
    check("pass_lit0", sout(0), 1000);
    check("pass_lit1", sout(1), -1000);

    // Impulse with feedback b1 = -0.5 on stage 0
    wcoef(3, -8192); commit();
    run_frame(16000, 16000, 0, 0, 0, 0, "imp0");
    check("imp0_lit", sout(0), 16000);
    run_frame(0, 0, 0, 0, 0, 0, "imp1");
    check("imp1_lit", sout(0), 8000);
    run_frame(0, 0, 0, 0, 0, 0, "imp2");
    check("imp2_lit", sout(0), 4000);
    run_frame(0, 0, 0, 0, 0, 0, "imp3");
    check("imp3_lit", sout(0), 2000);

    // Saturation with a0 = 1.5
    clear_idle();
    wcoef(3, 0); wcoef(0, 24576); commit();
    run_frame(30000, -30000, 0, 0, 0, 0, "sat");
    check("sat_hi", sout(0), 32767);
    check("sat_lo", sout(1), -32768);

    // Cascade of two halves, shadow write without and then with commit
    wcoef(0, 8192); wcoef(5, 8192); commit();
    run_frame(8000, 123, 0, 0, 0, 0, "casc0");
    check("casc0_lit", sout(0), 2000);
    wcoef(0, 16384); wcoef(5, 16384);
    wcoef(10, 777); wcoef(200, -5);
    run_frame(8000, 123, 0, 0, 0, 0, "casc1");
    check("casc1_lit", sout(0), 2000);
    commit();
    run_frame(8000, 123, 0, 0, 0, 0, "casc2");
    check("casc2_lit", sout(0), 8000);

    // Second frame start while running
    run_frame(rnd16(), rnd16(), 10, 0, 0, 0, "ovr");

    // Clear latched during a frame: output kept, next frame starts from zero
    wcoef(3, -8192); commit();
    run_frame(16000, 500, 0, 5, 0, 0, "clr0");
    check("clr0_lit", sout(0), 16000);
    run_frame(0, 0, 0, 0, 0, 0, "clr1");
    check("clr1_lit", sout(0), 0);

    // Commit coincident with the start edge takes effect on that frame
    wcoef(3, 0);
    run_frame(16000, 0, 0, 0, 0, 0, "cmt_s0");
    run_frame(0, 0, 0, 0, 0, 0, "cmt_s1");
    check("cmt_s1_lit", sout(0), 8000);
    clear_idle();
    wcoef(3, -8192);
    run_frame(16000, 0, 0, 0, 0, 1, "cmt_s2");
    run_frame(0, 0, 0, 0, 0, 0, "cmt_s3");
    check("cmt_s3_lit", sout(0), 8000);
    wcoef(3, 0);
    run_frame(16000, 0, 0, 0, 0, 1, "cmt_s4");
    run_frame(0, 0, 0, 0, 0, 0, "cmt_s5");
    check("cmt_s5_lit", sout(0), 0);

    // Reset in the middle of a frame
    run_frame(1234, -1234, 0, 0, 5, 0, "rst_mid");
    run_frame(5000, 5000, 0, 0, 0, 0, "rst_zero_coef");
    check("rst_zero_lit", sout(0), 0);

    // Random coefficient sets and samples
    for (int r = 0; r < 5; r++) begin
      for (int a = 0; a < ST*5; a++) wcoef(a, rnd16());
      wcoef(ST*5 + int'($urandom_range(0, 100)), rnd16());
      commit();
      for (int f = 0; f < 3; f++) run_frame(rnd16(), rnd16(), 0, 0, 0, 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
